// File: rtl/load_store_unit.sv
// RV32 memory stage: one load/store per transaction, run as a request/response handshake with data memory.
// Formats store lanes/masks and load results, and reports misaligned, illegal and timed-out accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_wr,
    input  logic [2:0]  io_req_typ,
    input  logic [31:0] io_req_addr,
    input  logic [31:0] io_req_wdata,
    output logic        io_dmem_req_valid,
    input  logic        io_dmem_req_ready,
    output logic [31:0] io_dmem_addr,
    output logic        io_dmem_wen,
    output logic [3:0]  io_dmem_wmask,
    output logic [31:0] io_dmem_wdata,
    input  logic        io_dmem_resp_valid,
    input  logic [31:0] io_dmem_resp_data,
    output logic        io_resp_valid,
    output logic [31:0] io_wb_mem,
    output logic        io_stall,
    output logic        io_xcpt,
    output logic [1:0]  io_xcpt_cause,
    output logic [31:0] io_xcpt_addr
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              wr_p0;
    logic [2:0]        typ_p0;
    logic [31:0]       addr_p0, wdata_p0;
    logic              resp_valid_q, xcpt_q;
    logic [1:0]        cause_q;
    logic [31:0]       xcpt_addr_q, wb_mem_q;
    logic              accept, illegal, misaligned, op_xcpt, resp_hit, timeout;

    function automatic logic [31:0] store_data(input logic [2:0] typ, input logic [31:0] wdata);
        case (typ[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic wr, input logic [2:0] typ,
                                              input logic [1:0] lane);
        if (!wr) return 4'b0000;
        case (typ[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] typ, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (typ)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b100:  ext = {24'b0, b};
            3'b101:  ext = {16'b0, h};
            default: ext = word;
        endcase
        return ext;
    endfunction

    always_comb begin
        state_nxt  = state;
        resp_hit   = 1'b0;
        timeout    = 1'b0;
        accept     = io_req_valid & io_req_ready;
        illegal    = (io_req_typ == 3'b011) || (io_req_typ == 3'b110) || (io_req_typ == 3'b111)
                     || (io_req_wr && io_req_typ[2]);
        misaligned = ((io_req_typ[1:0] == 2'b01) && io_req_addr[0])
                     || ((io_req_typ == 3'b010) && (io_req_addr[1:0] != 2'b00));
        op_xcpt    = accept && (illegal || misaligned);
        case (state)
            IDLE: if (accept && !op_xcpt) state_nxt = REQ;
            REQ:  if (io_dmem_req_ready) state_nxt = WAIT;
            WAIT: begin
                resp_hit = io_dmem_resp_valid;
                timeout  = !io_dmem_resp_valid && (cnt == CNT_LAST);
                if (resp_hit || timeout) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // control stage: FSM, timeout counter, completion/exception pulses, writeback operand
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            resp_valid_q <= 1'b0;
            xcpt_q       <= 1'b0;
            cause_q      <= 2'b00;
            wb_mem_q     <= '0;
        end else begin
            state        <= state_nxt;
            resp_valid_q <= resp_hit;
            xcpt_q       <= op_xcpt || timeout;
            if (timeout)      cause_q <= 2'b11;
            else if (op_xcpt) cause_q <= illegal ? 2'b10 : 2'b01;
            else              cause_q <= 2'b00;
            if (state == REQ)       cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CNT_W'(1);
            if (resp_hit && !wr_p0)
                wb_mem_q <= load_fmt(typ_p0, addr_p0[1:0], io_dmem_resp_data);
        end
    end

    // request capture stage: operands held stable for the memory handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_p0    <= io_req_wr;
            typ_p0   <= io_req_typ;
            addr_p0  <= io_req_addr;
            wdata_p0 <= io_req_wdata;
        end
        if (op_xcpt)      xcpt_addr_q <= io_req_addr;
        else if (timeout) xcpt_addr_q <= addr_p0;
    end

    assign io_req_ready      = (state == IDLE) && !resp_valid_q && !xcpt_q;
    assign io_stall          = io_req_valid && !resp_valid_q && !xcpt_q;
    assign io_dmem_req_valid = (state == REQ);
    assign io_dmem_addr      = {addr_p0[31:2], 2'b00};
    assign io_dmem_wen       = wr_p0;
    assign io_dmem_wmask     = store_mask(wr_p0, typ_p0, addr_p0[1:0]);
    assign io_dmem_wdata     = store_data(typ_p0, wdata_p0);
    assign io_resp_valid     = resp_valid_q;
    assign io_wb_mem         = wb_mem_q;
    assign io_xcpt           = xcpt_q;
    assign io_xcpt_cause     = cause_q;
    assign io_xcpt_addr      = xcpt_addr_q;
endmodule
